// File: rtl/iq2saw.sv
// iq2saw: converts a signed I/Q pair into a 16-bit sawtooth phase word and a
// gain-scaled magnitude using an iterative vectoring CORDIC, one micro-rotation
// per clock, with valid/ready handshakes on input and output.
module iq2saw #(
    parameter int ITERS = 16,
    parameter int ZG    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic signed [15:0] i_cos,
    input  logic signed [15:0] i_sin,
    input  logic               i_valid,
    output logic               o_ready,
    output logic        [15:0] o_saw,
    output logic        [16:0] o_mag,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int            ZW     = 16 + ZG;
    localparam int            CW     = 5;
    localparam logic [CW-1:0] LAST   = CW'(ITERS - 1);
    localparam logic [ZW-1:0] Z_HALF = {1'b1, {(ZW-1){1'b0}}};
    localparam logic [ZW-1:0] Z_RND  = ZW'(1) << (ZG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) as a turn fraction scaled to 2^32 per turn.
    function automatic logic [31:0] atan_turn32(input logic [CW-1:0] i);
        case (i)
            5'd0:    return 32'h2000_0000;
            5'd1:    return 32'h12E4_051E;
            5'd2:    return 32'h09FB_385B;
            5'd3:    return 32'h0511_11D4;
            5'd4:    return 32'h028B_0D43;
            5'd5:    return 32'h0145_D7E1;
            5'd6:    return 32'h00A2_F61E;
            5'd7:    return 32'h0051_7C55;
            5'd8:    return 32'h0028_BE53;
            5'd9:    return 32'h0014_5F2F;
            5'd10:   return 32'h000A_2F98;
            5'd11:   return 32'h0005_17CC;
            5'd12:   return 32'h0002_8BE6;
            5'd13:   return 32'h0001_45F3;
            5'd14:   return 32'h0000_A2FA;
            5'd15:   return 32'h0000_517D;
            5'd16:   return 32'h0000_28BE;
            5'd17:   return 32'h0000_145F;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Rescale the 32-bit turn angle to the accumulator width, rounding to nearest.
    function automatic logic [ZW-1:0] atan_z(input logic [CW-1:0] i);
        return ZW'(({1'b0, atan_turn32(i)} + (33'd1 << (15 - ZG))) >> (16 - ZG));
    endfunction

    // Drop the guard bits with round-half-up; the phase wraps modulo one turn.
    function automatic logic [15:0] round_saw(input logic [ZW-1:0] zz);
        return 16'((zz + Z_RND) >> ZG);
    endfunction

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic signed [17:0] cos_ext, sin_ext;
    logic signed [17:0] x, y, x_ld, y_ld, x_sh, y_sh, x_rot, y_rot;
    logic [ZW-1:0]      z, z_ld, z_rot;
    logic               zero_in;
    logic               accept;
    logic               last_iter;

    assign accept    = i_valid && o_ready;
    assign last_iter = (state == ITER) && (cnt == LAST);

    // Pre-rotation: fold the left half-plane onto the right by a 180 degree turn.
    always_comb begin
        cos_ext = {{2{i_cos[15]}}, i_cos};
        sin_ext = {{2{i_sin[15]}}, i_sin};
        if (i_cos[15]) begin
            x_ld = -cos_ext;
            y_ld = -sin_ext;
            z_ld = Z_HALF;
        end else begin
            x_ld = cos_ext;
            y_ld = sin_ext;
            z_ld = '0;
        end
    end

    // Micro-rotation cnt: drive y toward zero, accumulating the angle in z.
    always_comb begin
        x_sh = x >>> cnt;
        y_sh = y >>> cnt;
        if (!y[17]) begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_z(cnt);
        end else begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - atan_z(cnt);
        end
    end

    // Datapath registers: load on accept, then rotate once per ITER cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            x       <= x_ld;
            y       <= y_ld;
            z       <= z_ld;
            zero_in <= (i_cos == 16'sd0) && (i_sin == 16'sd0);
        end else if (state == ITER) begin
            x <= x_rot;
            y <= y_rot;
            z <= z_rot;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ITER;
            ITER:    if (last_iter) state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; reset blocks acceptance immediately.
    always_comb begin
        o_ready = (state == IDLE) && !i_rst;
        o_valid = (state == DONE);
    end

    // Iteration counter and result latch; a zero vector has no defined angle so it reports 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            o_saw <= '0;
            o_mag <= '0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (state == ITER) begin
                cnt <= cnt + CW'(1);
            end
            if (last_iter) begin
                o_saw <= zero_in ? 16'h0000 : round_saw(z_rot);
                o_mag <= zero_in ? 17'h0_0000 : x_rot[16:0];
            end
        end
    end

endmodule

// File: tb/tb_iq2saw.sv
// Directed testbench for iq2saw: reset, cardinal/diagonal angles, wrap,
// zero vector, output backpressure and mid-operation reset.
module tb_iq2saw;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] cos_in;
    logic signed [15:0] sin_in;
    logic               in_valid;
    logic               out_ready;
    logic               dut_ready;
    logic        [15:0] saw;
    logic        [16:0] mag;
    logic               dut_valid;

    int checks = 0;
    int errors = 0;

    iq2saw #(.ITERS(16), .ZG(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_cos  (cos_in),
        .i_sin  (sin_in),
        .i_valid(in_valid),
        .o_ready(dut_ready),
        .o_saw  (saw),
        .o_mag  (mag),
        .o_valid(dut_valid),
        .i_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int angerr(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a - b;
        return d[15] ? (65536 - int'(d)) : int'(d);
    endfunction

    function automatic int magerr(input logic [16:0] a, input int b);
        int d;
        d = int'(a) - b;
        return (d < 0) ? -d : d;
    endfunction

    // Present one sample, wait for acceptance, then count cycles until o_valid.
    task automatic send(input logic signed [15:0] c, input logic signed [15:0] s,
                        output int lat, output logic [15:0] rs, output logic [16:0] rm);
        int w;
        cos_in   = c;
        sin_in   = s;
        in_valid = 1'b1;
        w = 0;
        while (dut_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (dut_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        rs = saw;
        rm = mag;
    endtask

    task automatic test_reset();
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b1;
        cos_in    = 16'sd1000;
        sin_in    = 16'sd0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: got %b want 0", i, dut_ready);
            end
            checks++;
            if (dut_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cyc%0d: got %b want 0", i, dut_valid);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (dut_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", dut_ready);
        end
        checks++;
        if (saw !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_saw: got %h want 0000", saw);
        end
        checks++;
        if (mag !== 17'h0) begin
            errors++;
            $display("FAIL post_reset_mag: got %0d want 0", mag);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dut_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL stray_result: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_cardinal();
        int          cv [6] = '{32767, 0, -32768, 0, 23170, -23170};
        int          sv [6] = '{0, 32767, 0, -32768, 23170, -23170};
        logic [15:0] ev [6] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hA000};
        int          mv [6] = '{53962, -1, 53963, -1, -1, -1};
        int          lat;
        logic [15:0] rs;
        logic [16:0] rm;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(16'(cv[i]), 16'(sv[i]), lat, rs, rm);
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL card%0d_latency: got %0d want 16", i, lat);
            end
            checks++;
            if ($isunknown(rs) || angerr(rs, ev[i]) > 2) begin
                errors++;
                $display("FAIL card%0d_saw: got %h want %h+-2", i, rs, ev[i]);
            end
            if (mv[i] >= 0) begin
                checks++;
                if ($isunknown(rm) || magerr(rm, mv[i]) > 4) begin
                    errors++;
                    $display("FAIL card%0d_mag: got %0d want %0d+-4", i, rm, mv[i]);
                end
            end
            step();
            checks++;
            if (dut_valid !== 1'b0) begin
                errors++;
                $display("FAIL card%0d_consume: got valid %b want 0", i, dut_valid);
            end
        end
    endtask

    task automatic test_wrap();
        int          lat;
        logic [15:0] rs;
        logic [16:0] rm;
        out_ready = 1'b1;
        send(16'sd32767, -16'sd1, lat, rs, rm);
        checks++;
        if ($isunknown(rs) || angerr(rs, 16'h0000) > 2) begin
            errors++;
            $display("FAIL wrap_low_saw: got %h want 0000+-2", rs);
        end
        step();
        send(-16'sd32768, 16'sd1, lat, rs, rm);
        checks++;
        if ($isunknown(rs) || angerr(rs, 16'h8000) > 2) begin
            errors++;
            $display("FAIL wrap_half_saw: got %h want 8000+-2", rs);
        end
        step();
    endtask

    task automatic test_zero();
        int          lat;
        logic [15:0] rs;
        logic [16:0] rm;
        out_ready = 1'b1;
        send(16'sd0, 16'sd0, lat, rs, rm);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 16", lat);
        end
        checks++;
        if (rs !== 16'h0000) begin
            errors++;
            $display("FAIL zero_saw: got %h want 0000", rs);
        end
        checks++;
        if (rm !== 17'h0) begin
            errors++;
            $display("FAIL zero_mag: got %0d want 0", rm);
        end
        step();
    endtask

    task automatic test_backpressure();
        int          lat;
        int          bad;
        logic [15:0] rs;
        logic [16:0] rm;
        out_ready = 1'b0;
        send(16'sd23170, 16'sd23170, lat, rs, rm);
        checks++;
        if ($isunknown(rs) || angerr(rs, 16'h2000) > 2) begin
            errors++;
            $display("FAIL bp_first_saw: got %h want 2000+-2", rs);
        end
        cos_in   = 16'sd0;
        sin_in   = 16'sd32767;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dut_valid !== 1'b1 || saw !== rs || mag !== rm || dut_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (dut_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_consume_valid: got %b want 0", dut_valid);
        end
        checks++;
        if (dut_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume_ready: got %b want 1", dut_ready);
        end
        step();
        checks++;
        if (dut_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: got ready %b want 0", dut_ready);
        end
        in_valid = 1'b0;
        lat = 0;
        while (dut_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL bp_second_latency: got %0d want 16", lat);
        end
        checks++;
        if ($isunknown(saw) || angerr(saw, 16'h4000) > 2) begin
            errors++;
            $display("FAIL bp_second_saw: got %h want 4000+-2", saw);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int          seen;
        int          lat;
        logic [15:0] rs;
        logic [16:0] rm;
        out_ready = 1'b1;
        cos_in    = 16'sd0;
        sin_in    = 16'sd32767;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (dut_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %b want 0", dut_valid);
        end
        checks++;
        if (dut_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b want 1", dut_ready);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dut_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_stray: got %0d valid cycles want 0", seen);
        end
        send(16'sd32767, 16'sd0, lat, rs, rm);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL midrst_after_latency: got %0d want 16", lat);
        end
        checks++;
        if ($isunknown(rs) || angerr(rs, 16'h0000) > 2) begin
            errors++;
            $display("FAIL midrst_after_saw: got %h want 0000+-2", rs);
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        cos_in    = '0;
        sin_in    = '0;
        out_ready = 1'b1;
        test_reset();
        test_cardinal();
        test_wrap();
        test_zero();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq2saw.md
Name: iq2saw

Overview:
- Inverse of the phase-to-sine path: converts a signed cosine/sine (I/Q) sample pair into a 16-bit sawtooth phase word plus an uncompensated magnitude.
- Uses an iterative vectoring-mode CORDIC, one micro-rotation per clock, behind valid/ready handshakes on both sides.
- Phase format matches the codebase saw convention: unsigned turn fraction, 0x0000=0°, 0x4000=90°, 0x8000=180°, 0xC000=270°.

Parameters:
ITERS, 16, number of CORDIC micro-rotations; legal range 8..18.
ZG, 4, guard bits below the 16-bit phase LSB in the angle accumulator.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_cos  input  16  signed two's-complement I component
i_sin  input  16  signed two's-complement Q component
i_valid  input  1  input sample valid
o_ready  output  1  block can accept a sample
o_saw  output  16  phase, turn fraction, wraps mod 2^16
o_mag  output  17  unsigned magnitude times CORDIC gain (~1.6468)
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values:
  - o_valid=0, o_saw=0, o_mag=0.
  - State IDLE, iteration counter 0.
- o_ready: combinational, = (state==IDLE) && !i_rst. A sample presented while i_rst=1 is never accepted.
- States:
  - IDLE: on i_valid && o_ready at edge k, capture the sample, pre-rotate and load, go to ITER with cnt=0.
  - ITER: each edge performs micro-rotation cnt, then cnt++. After rotation ITERS-1 (edge k+ITERS), latch o_saw and o_mag, set o_valid=1, go to DONE.
  - DONE: hold o_valid, o_saw and o_mag stable while i_ready=0. On o_valid && i_ready, clear o_valid and return to IDLE.
  - i_valid is ignored outside IDLE.
- Latency and throughput:
  - Latency from accept edge to o_valid high is exactly ITERS cycles.
  - Minimum spacing between accepts is ITERS+2 cycles.
- Datapath widths:
  - x and y: 18-bit signed. Covers sqrt(2)*32768*1.647 < 2^17, including the -32768 negation.
  - z: (16+ZG)-bit unsigned, modular arithmetic.
- Pre-rotation:
  - If i_cos<0: x=-i_cos, y=-i_sin, z=0x8000<<ZG.
  - Otherwise: x=i_cos, y=i_sin, z=0.
- Micro-rotation i:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=A[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=A[i].
  - Shifts use the pre-update x and y.
  - A[i] = round(atan(2^-i)/(2π) * 2^(16+ZG)); constant table of 18 entries.
- Outputs:
  - o_saw = (z + 2^(ZG-1)) >> ZG, truncated to 16 bits (rounded, wraps).
  - o_mag = x[16:0] (x is never negative after the rotations).
- Zero input (i_cos=0, i_sin=0): o_saw=0x0000 and o_mag=0, forced at load. The same latency and handshake still apply.
- Accuracy, ITERS=16: |o_saw − round(atan2(sin,cos)*65536/2π) mod 2^16| ≤ 2 LSB, measured modulo 2^16. o_mag within ±4 of 1.6468*sqrt(cos²+sin²).
- Reset mid-operation (ITER or DONE): the edge with i_rst=1 forces IDLE and o_valid=0. The aborted sample produces no output.
- Simultaneous o_valid && i_ready in DONE and i_valid at the same edge: the result is consumed; the new sample is not accepted that edge because o_ready=0.

Test Plan:
- Reset: i_rst=1 for 3 cycles with i_valid=1, cos=1000 -> o_ready=0 and o_valid=0 throughout. Cycle after release: o_ready=1, o_saw=0, o_mag=0, no stray result.
- Cardinal/diagonal points, i_ready=1 -> o_valid exactly 16 cycles after accept, o_saw within ±2 of target:
  - (32767,0)->0x0000, o_mag 53962±4
  - (0,32767)->0x4000
  - (-32768,0)->0x8000, o_mag 53963±4
  - (0,-32768)->0xC000
  - (23170,23170)->0x2000
  - (-23170,-23170)->0xA000
- Wrap: (32767,-1) -> o_saw ∈ {0xFFFE..0x0002} mod 2^16. (-32768,1) -> o_saw within ±2 of 0x8000, no sign fault.
- Zero vector: (0,0) -> o_saw=0x0000, o_mag=0 after 16 cycles.
- Backpressure: hold i_ready=0 for 10 cycles in DONE with i_valid=1 and new data -> o_valid, o_saw and o_mag stable, o_ready=0. After the i_ready pulse, the next accept occurs 1 cycle later and the new result is correct.
- Mid-operation reset: accept (0,32767), pulse i_rst at iteration 5 -> o_valid=0 and o_ready=1 next cycle, no 0x4000 output. A following (32767,0) returns 0x0000±2.
